imm_extend_unit: RTL



---
 rtl/imm_extend_if.sv | 29 ++
 rtl/imm_extend_unit.sv | 105 ++++++++++
 2 files changed

// File: rtl/imm_extend_if.sv
// Decode-to-ALU immediate bundle: request fields in, extended
// constant and prefix status out.
interface imm_extend_if #(
  parameter int IN_W  = 4,
  parameter int PFX_W = 8,
  parameter int OUT_W = 16
) ();
  logic             VALID_I;
  logic             STALL_I;
  logic             FLUSH_I;
  logic [1:0]       MODE_I;
  logic [IN_W-1:0]  CONST_I;
  logic [PFX_W-1:0] PFX_I;
  logic [OUT_W-1:0] CONST_O;
  logic             VALID_O;
  logic             PFX_PEND_O;

  modport master (
    output VALID_I, STALL_I, FLUSH_I,
    output MODE_I, CONST_I, PFX_I,
    input  CONST_O, VALID_O, PFX_PEND_O
  );

  modport slave (
    input  VALID_I, STALL_I, FLUSH_I,
    input  MODE_I, CONST_I, PFX_I,
    output CONST_O, VALID_O, PFX_PEND_O
  );
endinterface

// File: rtl/imm_extend_unit.sv
// Registered immediate extension stage: sign, zero, sign+shl1,
// with a latched high-order prefix for wide immediates.
module imm_extend_unit #(
  parameter int IN_W  = 4,
  parameter int PFX_W = 8,
  parameter int OUT_W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  imm_extend_if.slave  bus
);
  localparam int WW = IN_W + PFX_W;

  if ((WW > OUT_W) || (IN_W < 2)) begin : g_bad_params
    $error("imm_extend_unit: illegal IN_W/PFX_W/OUT_W");
  end

  typedef enum logic [1:0] {
    M_SIGN = 2'b00,
    M_ZERO = 2'b01,
    M_SHL1 = 2'b10,
    M_PFX  = 2'b11
  } mode_e;

  logic [OUT_W-1:0] const_q, const_d;
  logic             valid_q, valid_d;
  logic             pend_q, pend_d;
  logic [PFX_W-1:0] pfx_q, pfx_d;

  logic [WW-1:0]    wide;
  logic [OUT_W-1:0] ext_s, ext_z;
  mode_e            mode;

  assign mode = mode_e'(bus.MODE_I);
  assign wide = {pfx_q, bus.CONST_I};

  // Sized casts of signed operands sign-extend; of unsigned, zero-fill.
  always_comb begin
    if (pend_q) begin
      ext_s = OUT_W'($signed(wide));
      ext_z = OUT_W'(wide);
    end else begin
      ext_s = OUT_W'($signed(bus.CONST_I));
      ext_z = OUT_W'(bus.CONST_I);
    end
  end

  always_comb begin
    const_d = const_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    pfx_d   = pfx_q;
    if (bus.FLUSH_I) begin
      valid_d = 1'b0;
      pend_d  = 1'b0;
      pfx_d   = '0;
    end else if (bus.STALL_I) begin
      valid_d = valid_q;
    end else if (bus.VALID_I) begin
      unique case (mode)
        M_PFX: begin
          pfx_d   = bus.PFX_I;
          pend_d  = 1'b1;
          valid_d = 1'b0;
        end
        M_SIGN: begin
          const_d = ext_s;
          valid_d = 1'b1;
          pend_d  = 1'b0;
        end
        M_ZERO: begin
          const_d = ext_z;
          valid_d = 1'b1;
          pend_d  = 1'b0;
        end
        M_SHL1: begin
          const_d = {ext_s[OUT_W-2:0], 1'b0};
          valid_d = 1'b1;
          pend_d  = 1'b0;
        end
        default: valid_d = 1'b0;
      endcase
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      const_q <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      pfx_q   <= '0;
    end else begin
      const_q <= const_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      pfx_q   <= pfx_d;
    end
  end

  assign bus.CONST_O    = const_q;
  assign bus.VALID_O    = valid_q;
  assign bus.PFX_PEND_O = pend_q;
endmodule
